// File: rtl/voice_scheduler_pkg.sv
// Shared types and constants for the polyphonic voice scheduler and its
// per-voice parameter store.
package voice_scheduler_pkg;

    localparam int SLOT_LEN  = 4;
    localparam int DRAIN_LEN = 8;
    localparam int ADDR_W    = 10;
    localparam int SAMPLE_W  = 18;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE_R,
        ISSUE_L,
        HOLD1,
        HOLD2,
        DRAIN
    } sched_state_t;

    typedef struct packed {
        logic                gate;
        logic [ADDR_W-1:0]   spread;
        logic [SAMPLE_W-1:0] velocity;
        logic [SAMPLE_W-1:0] volume;
    } voice_params_t;

endpackage

// File: rtl/voice_scheduler_param_ram.sv
// Per-voice register file: config write port, asynchronous read port for the
// scheduler, and a phase write-back port from the issue slot.
module voice_param_ram
    import voice_scheduler_pkg::*;
#(
    parameter  int NUM_VOICES = 16,
    parameter  int PHASE_W    = 24,
    localparam int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_voice,
    input  voice_params_t      cfg_params,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic [IDX_W-1:0]   rd_voice,
    output voice_params_t      rd_params,
    output logic [PHASE_W-1:0] rd_inc,
    output logic [PHASE_W-1:0] rd_phase,
    input  logic               wb_en,
    input  logic [IDX_W-1:0]   wb_voice,
    input  logic [PHASE_W-1:0] wb_phase
);

    voice_params_t      params_q [NUM_VOICES];
    logic [PHASE_W-1:0] inc_q    [NUM_VOICES];
    logic [PHASE_W-1:0] phase_q  [NUM_VOICES];
    logic               gate_rise;

    // A note-on restarts the voice from phase 0, even over a same-cycle write-back.
    assign gate_rise = cfg_we && cfg_params.gate && !params_q[cfg_voice].gate;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                params_q[i] <= '0;
                inc_q[i]    <= '0;
                phase_q[i]  <= '0;
            end
        end else begin
            if (cfg_we) begin
                params_q[cfg_voice] <= cfg_params;
                inc_q[cfg_voice]    <= cfg_inc;
            end
            if (wb_en && !(gate_rise && (cfg_voice == wb_voice))) begin
                phase_q[wb_voice] <= wb_phase;
            end
            if (gate_rise) begin
                phase_q[cfg_voice] <= '0;
            end
        end
    end

    assign rd_params = params_q[rd_voice];
    assign rd_inc    = inc_q[rd_voice];
    assign rd_phase  = phase_q[rd_voice];

endmodule

// File: rtl/voice_scheduler.sv
// Walks all voices once per sample tick, issuing right/left wavetable
// addresses plus envelope and velocity to the shared soundgen datapath.
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter  int NUM_VOICES = 16,
    parameter  int PHASE_W    = 24,
    localparam int IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick48k,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_voice,
    input  logic                cfg_gate,
    input  logic [PHASE_W-1:0]  cfg_inc,
    input  logic [ADDR_W-1:0]   cfg_spread,
    input  logic [SAMPLE_W-1:0] cfg_velocity,
    input  logic [SAMPLE_W-1:0] cfg_volume,
    output logic [ADDR_W-1:0]   wavetable_r,
    output logic                wavetable_r_valid,
    output logic [ADDR_W-1:0]   wavetable_l,
    output logic                wavetable_l_valid,
    output logic [SAMPLE_W-1:0] volume_adsr,
    output logic [SAMPLE_W-1:0] velocity,
    output logic                busy,
    output logic                overrun
);

    localparam int DRAIN_CNT_W = $clog2(DRAIN_LEN);

    sched_state_t           state, state_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [DRAIN_CNT_W-1:0] drain_cnt, drain_cnt_n;
    logic                   last_voice;
    logic                   wb_en;
    logic                   issue;

    voice_params_t          cfg_params;
    voice_params_t          rd_params;
    logic [PHASE_W-1:0]     rd_inc, rd_phase;
    logic [PHASE_W-1:0]     lat_phase, lat_inc;
    logic [ADDR_W-1:0]      lat_spread;

    assign cfg_params = '{gate: cfg_gate, spread: cfg_spread,
                          velocity: cfg_velocity, volume: cfg_volume};

    voice_param_ram #(
        .NUM_VOICES(NUM_VOICES),
        .PHASE_W   (PHASE_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_voice (cfg_voice),
        .cfg_params(cfg_params),
        .cfg_inc   (cfg_inc),
        .rd_voice  (idx),
        .rd_params (rd_params),
        .rd_inc    (rd_inc),
        .rd_phase  (rd_phase),
        .wb_en     (wb_en),
        .wb_voice  (idx),
        .wb_phase  (lat_phase + lat_inc)
    );

    assign last_voice = (idx == IDX_W'(NUM_VOICES - 1));
    assign issue      = (state == SCAN) && rd_params.gate;

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        drain_cnt_n = drain_cnt;
        wb_en       = 1'b0;
        case (state)
            IDLE: begin
                if (tick48k) begin
                    idx_n   = '0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (rd_params.gate) begin
                    state_n = ISSUE_R;
                end else if (last_voice) begin
                    state_n     = DRAIN;
                    drain_cnt_n = '0;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
            ISSUE_R: state_n = ISSUE_L;
            ISSUE_L: begin
                wb_en   = 1'b1;
                state_n = HOLD1;
            end
            HOLD1:   state_n = HOLD2;
            HOLD2: begin
                if (last_voice) begin
                    state_n     = DRAIN;
                    drain_cnt_n = '0;
                end else begin
                    idx_n   = idx + 1'b1;
                    state_n = SCAN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_CNT_W'(DRAIN_LEN - 1)) begin
                    state_n = IDLE;
                end else begin
                    drain_cnt_n = drain_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Valid strobes are single-cycle and unconditional: soundgen has no
    // back-pressure, it consumes each address in the cycle its valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            idx               <= '0;
            drain_cnt         <= '0;
            busy              <= 1'b0;
            overrun           <= 1'b0;
            wavetable_r       <= '0;
            wavetable_l       <= '0;
            wavetable_r_valid <= 1'b0;
            wavetable_l_valid <= 1'b0;
            volume_adsr       <= '0;
            velocity          <= '0;
            lat_phase         <= '0;
            lat_inc           <= '0;
            lat_spread        <= '0;
        end else begin
            state             <= state_n;
            idx               <= idx_n;
            drain_cnt         <= drain_cnt_n;
            busy              <= (state_n != IDLE);
            overrun           <= overrun | (tick48k & busy);
            wavetable_r_valid <= issue;
            wavetable_l_valid <= (state == ISSUE_R);
            if (issue) begin
                wavetable_r <= rd_phase[PHASE_W-1 -: ADDR_W];
                volume_adsr <= rd_params.volume;
                velocity    <= rd_params.velocity;
                lat_phase   <= rd_phase;
                lat_inc     <= rd_inc;
                lat_spread  <= rd_params.spread;
            end
            if (state == ISSUE_R) begin
                wavetable_l <= wavetable_r + lat_spread;
            end
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: event-time reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_voice_scheduler;
    import voice_scheduler_pkg::*;

    localparam int NV = 16;
    localparam int PW = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick48k = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_voice = '0;
    logic        cfg_gate = 1'b0;
    logic [23:0] cfg_inc = '0;
    logic [9:0]  cfg_spread = '0;
    logic [17:0] cfg_velocity = '0;
    logic [17:0] cfg_volume = '0;
    logic [9:0]  wavetable_r, wavetable_l;
    logic        wavetable_r_valid, wavetable_l_valid;
    logic [17:0] volume_adsr, velocity;
    logic        busy, overrun;

    voice_scheduler #(.NUM_VOICES(NV), .PHASE_W(PW)) dut (
        .clk              (clk),
        .rst              (rst),
        .tick48k          (tick48k),
        .cfg_we           (cfg_we),
        .cfg_voice        (cfg_voice),
        .cfg_gate         (cfg_gate),
        .cfg_inc          (cfg_inc),
        .cfg_spread       (cfg_spread),
        .cfg_velocity     (cfg_velocity),
        .cfg_volume       (cfg_volume),
        .wavetable_r      (wavetable_r),
        .wavetable_r_valid(wavetable_r_valid),
        .wavetable_l      (wavetable_l),
        .wavetable_l_valid(wavetable_l_valid),
        .volume_adsr      (volume_adsr),
        .velocity         (velocity),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: voice storage plus the time of each pending event.
    logic        m_gate [NV];
    logic [23:0] m_inc [NV], m_phase [NV];
    logic [9:0]  m_spread [NV];
    logic [17:0] m_vel [NV], m_vol [NV];
    bit          sweeping;
    int          cur_v, next_scan_end, after, l_time, wb_time, wb_voice, busy_off;
    logic [23:0] wb_val;
    logic [9:0]  l_addr;
    bit          rising;
    logic        e_rv, e_lv, e_busy, e_ovr;
    logic [9:0]  e_r, e_l;
    logic [17:0] e_vol, e_vel;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                for (int i = 0; i < NV; i++) begin
                    m_gate[i] = 0; m_inc[i] = 0; m_phase[i] = 0;
                    m_spread[i] = 0; m_vel[i] = 0; m_vol[i] = 0;
                end
                sweeping = 0; busy_off = 0; l_time = -1; wb_time = -1;
                e_rv = 0; e_lv = 0; e_busy = 0; e_ovr = 0;
                e_r = 0; e_l = 0; e_vol = 0; e_vel = 0;
            end else begin
                e_rv = 0;
                e_lv = 0;
                if (tick48k) begin
                    if (e_busy) e_ovr = 1;
                    else begin
                        sweeping = 1; cur_v = 0; next_scan_end = cyc + 1;
                    end
                end
                if (sweeping && cyc == next_scan_end) begin
                    if (m_gate[cur_v]) begin
                        e_rv = 1;
                        e_r = 10'(m_phase[cur_v] / (1 << (PW - 10)));
                        e_vol = m_vol[cur_v];
                        e_vel = m_vel[cur_v];
                        l_addr = 10'((int'(e_r) + int'(m_spread[cur_v])) % 1024);
                        l_time = cyc + 1;
                        wb_time = cyc + 2;
                        wb_voice = cur_v;
                        wb_val = 24'((int'(m_phase[cur_v]) + int'(m_inc[cur_v])) % (1 << PW));
                        after = cyc + SLOT_LEN;
                    end else begin
                        after = cyc;
                    end
                    if (cur_v == NV - 1) begin
                        sweeping = 0; busy_off = after + DRAIN_LEN;
                    end else begin
                        cur_v++; next_scan_end = after + 1;
                    end
                end
                if (cyc == l_time) begin
                    e_lv = 1; e_l = l_addr;
                end
                if (cyc == wb_time) begin
                    rising = cfg_we && int'(cfg_voice) == wb_voice && cfg_gate && !m_gate[wb_voice];
                    if (!rising) m_phase[wb_voice] = wb_val;
                end
                if (cfg_we) begin
                    if (cfg_gate && !m_gate[cfg_voice]) m_phase[cfg_voice] = 0;
                    m_gate[cfg_voice] = cfg_gate;
                    m_inc[cfg_voice] = cfg_inc;
                    m_spread[cfg_voice] = cfg_spread;
                    m_vel[cfg_voice] = cfg_velocity;
                    m_vol[cfg_voice] = cfg_volume;
                end
                e_busy = sweeping || (cyc < busy_off);
            end
        end
    end

    // Per-cycle compare against the model, plus an observation log for the
    // directed scenarios.
    int          obs_r_cyc [$];
    logic [9:0]  obs_r [$], obs_l [$];
    logic [17:0] obs_vol [$], obs_vel [$];
    int          busy_cycles = 0;

    initial begin
        forever begin
            @(negedge clk);
            check("r_valid", wavetable_r_valid, e_rv);
            check("l_valid", wavetable_l_valid, e_lv);
            check("busy", busy, e_busy);
            check("overrun", overrun, e_ovr);
            check("wavetable_r", wavetable_r, e_r);
            check("wavetable_l", wavetable_l, e_l);
            check("volume_adsr", volume_adsr, e_vol);
            check("velocity", velocity, e_vel);
            if (wavetable_r_valid) begin
                obs_r.push_back(wavetable_r); obs_r_cyc.push_back(cyc);
                obs_vol.push_back(volume_adsr); obs_vel.push_back(velocity);
            end
            if (wavetable_l_valid) obs_l.push_back(wavetable_l);
            if (busy) busy_cycles++;
        end
    end

    task automatic clear_obs();
        obs_r.delete(); obs_r_cyc.delete(); obs_l.delete();
        obs_vol.delete(); obs_vel.delete();
        busy_cycles = 0;
    endtask

    task automatic cfg_write(input int v, input logic g, input logic [23:0] inc,
                             input logic [9:0] sp, input logic [17:0] vel, input logic [17:0] vol);
        cfg_we = 1; cfg_voice = 4'(v); cfg_gate = g; cfg_inc = inc;
        cfg_spread = sp; cfg_velocity = vel; cfg_volume = vol;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic send_tick();
        tick48k = 1;
        @(negedge clk);
        tick48k = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("sweep_done", busy, 0);
    endtask

    task automatic wait_r();
        bit got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wavetable_r_valid) begin
                got = 1;
                break;
            end
        end
        check("r_valid_seen", got, 1);
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    function automatic logic [31:0] first_r();
        return (obs_r.size() > 0) ? 32'(obs_r[0]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] first_l();
        return (obs_l.size() > 0) ? 32'(obs_l[0]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] first_vol();
        return (obs_vol.size() > 0) ? 32'(obs_vol[0]) : 32'hFFFF_FFFF;
    endfunction

    logic [9:0] t3_r [4];
    logic [9:0] t3_l [4];
    int         t0;
    bit         sp_ok;

    initial begin
        t3_r = '{10'h000, 10'h3FC, 10'h000, 10'h004};
        t3_l = '{10'h3FF, 10'h3FB, 10'h3FF, 10'h003};
        repeat (2) @(negedge clk);
        rst = 0;
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_r_valid", wavetable_r_valid, 0);
        check("rst_wavetable_r", wavetable_r, 0);

        // Single voice 3: address advances by one per sweep, three skipped scans.
        cfg_write(3, 1, 24'h004000, 10'h000, 18'h20000, 18'h3FFFF);
        for (int t = 0; t < 3; t++) begin
            clear_obs();
            t0 = cyc;
            send_tick();
            wait_idle();
            check("t1_pairs", obs_r.size() + obs_l.size(), 2);
            check("t1_r", first_r(), t);
            check("t1_l", first_l(), t);
            check("t1_latency", (obs_r_cyc.size() > 0) ? obs_r_cyc[0] - t0 : -1, 5);
            check("t1_volume", first_vol(), 18'h3FFFF);
        end

        // All voices active.
        for (int v = 0; v < NV; v++)
            cfg_write(v, 1, 24'($urandom), 10'($urandom), 18'($urandom), 18'($urandom));
        clear_obs();
        send_tick();
        wait_idle();
        check("t2_r_count", obs_r.size(), 16);
        check("t2_l_count", obs_l.size(), 16);
        sp_ok = 1;
        for (int i = 1; i < obs_r_cyc.size(); i++)
            if (obs_r_cyc[i] - obs_r_cyc[i-1] != 5) sp_ok = 0;
        check("t2_spacing", sp_ok, 1);
        check("t2_busy_len", busy_cycles, 88);

        // Voice 0 driven across the phase wrap with full spread.
        for (int v = 0; v < NV; v++) cfg_write(v, 0, 24'h0, 10'h0, 18'h0, 18'h0);
        cfg_write(0, 1, 24'hFF0000, 10'h3FF, 18'h00001, 18'h00002);
        for (int t = 0; t < 4; t++) begin
            if (t == 1) cfg_write(0, 1, 24'h010000, 10'h3FF, 18'h00001, 18'h00002);
            clear_obs();
            send_tick();
            wait_idle();
            check("t3_r", first_r(), t3_r[t]);
            check("t3_l", first_l(), t3_l[t]);
        end

        // Tick during a sweep of 8 voices.
        do_reset();
        for (int v = 0; v < NV; v += 2)
            cfg_write(v, 1, 24'($urandom), 10'($urandom), 18'($urandom), 18'($urandom));
        clear_obs();
        send_tick();
        repeat (19) @(negedge clk);
        send_tick();
        wait_idle();
        check("t4_overrun", overrun, 1);
        check("t4_r_count", obs_r.size(), 8);
        check("t4_busy_len", busy_cycles, 56);
        repeat (10) @(negedge clk);
        check("t4_overrun_sticky", overrun, 1);
        do_reset();
        check("t4_overrun_cleared", overrun, 0);

        // Note-on collision with voice 2's phase write-back.
        cfg_write(2, 1, 24'h014000, 10'h010, 18'h22222, 18'h11111);
        send_tick();
        wait_idle();
        clear_obs();
        send_tick();
        wait_r();
        cfg_write(2, 0, 24'h014000, 10'h010, 18'h22222, 18'h11111);
        check("t5_in_issue_l", wavetable_l_valid, 1);
        cfg_write(2, 1, 24'h004000, 10'h000, 18'h04444, 18'h33333);
        wait_idle();
        check("t5_old_r", first_r(), 10'h005);
        check("t5_old_l", first_l(), 10'h015);
        check("t5_old_vol", first_vol(), 18'h11111);
        clear_obs();
        send_tick();
        wait_idle();
        check("t5_new_r", first_r(), 10'h000);
        check("t5_new_vol", first_vol(), 18'h33333);

        // Reset in HOLD1 of voice 5.
        cfg_write(5, 1, 24'h00C000, 10'h020, 18'h00055, 18'h00066);
        cfg_write(9, 1, 24'h008000, 10'h040, 18'h00099, 18'h00088);
        send_tick();
        wait_r();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("t6_r_valid", wavetable_r_valid, 0);
        check("t6_l_valid", wavetable_l_valid, 0);
        check("t6_busy", busy, 0);
        clear_obs();
        send_tick();
        repeat (40) @(negedge clk);
        check("t6_no_issue", obs_r.size() + obs_l.size(), 0);

        // Randomized traffic, including mid-sweep writes and overlapping ticks.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rst = (i == 700);
            tick48k = ($urandom_range(0, 29) == 0);
            cfg_we = ($urandom_range(0, 3) == 0);
            cfg_voice = 4'($urandom_range(0, NV - 1));
            cfg_gate = ($urandom_range(0, 3) != 0);
            cfg_inc = 24'($urandom);
            cfg_spread = 10'($urandom);
            cfg_velocity = 18'($urandom);
            cfg_volume = 18'($urandom);
            @(negedge clk);
        end
        rst = 0; tick48k = 0; cfg_we = 0;
        repeat (120) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
